// File: rtl/hit_manager.sv
// Hit manager: turns the raw raccoon/car overlap flag into one confirmed hit per
// impact, owns the lives counter, and drives the grace, blink, respawn and
// game-over indications. Every output comes straight from a register.
module hit_manager #(
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned LIVES_W        = 3,
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned GRACE_CYCLES   = 25000000,
  parameter int unsigned BLINK_CYCLES   = 3125000
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  input  logic [1:0]         i_Game_State,
  input  logic               i_Collision,
  input  logic               i_Restart,
  output logic [LIVES_W-1:0] o_Lives,
  output logic               o_Hit,
  output logic               o_Respawn,
  output logic               o_Invulnerable,
  output logic               o_Blink,
  output logic               o_Game_Over
);

  localparam int unsigned GraceW = (GRACE_CYCLES > 1) ? $clog2(GRACE_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [GraceW-1:0]  GraceLoad   = GraceW'(GRACE_CYCLES - 1);
  localparam logic [BlinkW-1:0]  BlinkLast   = BlinkW'(BLINK_CYCLES - 1);
  localparam logic [7:0]         ConfirmLast = 8'(CONFIRM_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LivesStart  = LIVES_W'(START_LIVES);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StArmed   = 3'd1;
  localparam logic [2:0] StConfirm = 3'd2;
  localparam logic [2:0] StGrace   = 3'd3;
  localparam logic [2:0] StDead    = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               collision_q;
  logic [7:0]         confirm_q, confirm_d;
  logic [GraceW-1:0]  grace_q, grace_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               hit_q, hit_d;
  logic               respawn_q, respawn_d;
  logic               invuln_q, invuln_d;
  logic               blink_q, blink_d;
  logic               game_over_q, game_over_d;

  logic               take_hit;
  logic [LIVES_W-1:0] lives_dec;

  // Saturating decrement: lives never wrap below zero.
  always_comb begin
    lives_dec = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
  end

  // Next-state logic: restart/idle override, freeze, then per-state behaviour.
  always_comb begin
    state_d     = state_q;
    confirm_d   = confirm_q;
    grace_d     = grace_q;
    blink_cnt_d = blink_cnt_q;
    lives_d     = lives_q;
    hit_d       = 1'b0;
    respawn_d   = 1'b0;
    invuln_d    = invuln_q;
    blink_d     = blink_q;
    game_over_d = game_over_q;
    take_hit    = 1'b0;

    if (i_Restart || (i_Game_State == 2'b00)) begin
      state_d     = StIdle;
      confirm_d   = '0;
      grace_d     = '0;
      blink_cnt_d = '0;
      lives_d     = LivesStart;
      invuln_d    = 1'b0;
      blink_d     = 1'b0;
      game_over_d = 1'b0;
    end else if (i_Game_State[1]) begin
      // Win/clean: everything holds; only the pulses are suppressed.
    end else begin
      case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (collision_q) begin
            if (CONFIRM_CYCLES == 1) begin
              take_hit = 1'b1;
            end else begin
              state_d   = StConfirm;
              confirm_d = 8'd1;
            end
          end
        end
        StConfirm: begin
          if (!collision_q) begin
            state_d   = StArmed;
            confirm_d = '0;
          end else if (confirm_q == ConfirmLast) begin
            take_hit = 1'b1;
          end else begin
            confirm_d = confirm_q + 8'd1;
          end
        end
        StGrace: begin
          if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
          end
          if (grace_q != '0) begin
            grace_d = grace_q - GraceW'(1);
          end else if (!collision_q) begin
            // Leave only once the overlap has cleared, so it cannot re-hit.
            state_d     = StArmed;
            invuln_d    = 1'b0;
            blink_d     = 1'b0;
            blink_cnt_d = '0;
          end
        end
        StDead: begin
          lives_d     = '0;
          game_over_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase

      if (take_hit) begin
        hit_d     = 1'b1;
        confirm_d = '0;
        lives_d   = lives_dec;
        if (lives_dec == '0) begin
          state_d     = StDead;
          game_over_d = 1'b1;
        end else begin
          state_d     = StGrace;
          respawn_d   = 1'b1;
          grace_d     = GraceLoad;
          invuln_d    = 1'b1;
          blink_d     = 1'b1;
          blink_cnt_d = '0;
        end
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= StIdle;
      collision_q <= 1'b0;
      confirm_q   <= '0;
      grace_q     <= '0;
      blink_cnt_q <= '0;
      lives_q     <= LivesStart;
      hit_q       <= 1'b0;
      respawn_q   <= 1'b0;
      invuln_q    <= 1'b0;
      blink_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      collision_q <= i_Collision;
      confirm_q   <= confirm_d;
      grace_q     <= grace_d;
      blink_cnt_q <= blink_cnt_d;
      lives_q     <= lives_d;
      hit_q       <= hit_d;
      respawn_q   <= respawn_d;
      invuln_q    <= invuln_d;
      blink_q     <= blink_d;
      game_over_q <= game_over_d;
    end
  end

  assign o_Lives        = lives_q;
  assign o_Hit          = hit_q;
  assign o_Respawn      = respawn_q;
  assign o_Invulnerable = invuln_q;
  assign o_Blink        = blink_q;
  assign o_Game_Over    = game_over_q;

endmodule

// File: tb/tb_hit_manager.sv
// Directed bench for hit_manager with CONFIRM=4, GRACE=20, BLINK=5, START_LIVES=3.
module tb_hit_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] gs = 2'b00;
  logic       col = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] o_Lives;
  logic       o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over;

  int checks = 0;
  int errors = 0;

  hit_manager #(
    .START_LIVES   (3),
    .LIVES_W       (3),
    .CONFIRM_CYCLES(4),
    .GRACE_CYCLES  (20),
    .BLINK_CYCLES  (5)
  ) dut (
    .i_Clk         (clk),
    .i_Reset_n     (rst_n),
    .i_Game_State  (gs),
    .i_Collision   (col),
    .i_Restart     (restart),
    .o_Lives       (o_Lives),
    .o_Hit         (o_Hit),
    .o_Respawn     (o_Respawn),
    .o_Invulnerable(o_Invulnerable),
    .o_Blink       (o_Blink),
    .o_Game_Over   (o_Game_Over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raises collision and returns cycles from collision_q rising to o_Hit (-1 if none).
  task automatic hit_wait(output int lat);
    int k;
    col = 1'b1;
    step();
    lat = -1;
    k = 0;
    while (lat < 0 && k < 10) begin
      k++;
      step();
      if (o_Hit === 1'b1) lat = k;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gs = 2'b00;
    #12;
    checks++;
    if (o_Lives !== 3'd3) begin
      errors++;
      $display("FAIL reset_lives: got %0d expected 3", o_Lives);
    end
    checks++;
    if ({o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over});
    end
    @(negedge clk);
    rst_n = 1'b1;
    gs = 2'b01;
    step();
    checks++;
    if (o_Lives !== 3'd3 || {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over} !== 5'b0)
    begin
      errors++;
      $display("FAIL armed_state: got lives %0d flags %b expected lives 3 flags 00000", o_Lives,
               {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over});
    end
  endtask

  task automatic test_short_collision();
    int seen = 0;
    col = 1'b1;
    repeat (3) step();
    col = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_Hit === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL short_no_hit: got %0d hits expected 0", seen);
    end
    checks++;
    if (o_Lives !== 3'd3) begin
      errors++;
      $display("FAIL short_lives: got %0d expected 3", o_Lives);
    end
  endtask

  task automatic test_hit_latency();
    int lat;
    hit_wait(lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL hit_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({o_Respawn, o_Invulnerable, o_Blink, o_Game_Over} !== 4'b1110) begin
      errors++;
      $display("FAIL hit_flags: got resp/inv/blink/go %b expected 1110",
               {o_Respawn, o_Invulnerable, o_Blink, o_Game_Over});
    end
    checks++;
    if (o_Lives !== 3'd2) begin
      errors++;
      $display("FAIL hit_lives: got %0d expected 2", o_Lives);
    end
    step();
    checks++;
    if ({o_Hit, o_Respawn, o_Invulnerable, o_Blink} !== 4'b0011) begin
      errors++;
      $display("FAIL hit_one_pulse: got hit/resp/inv/blink %b expected 0011",
               {o_Hit, o_Respawn, o_Invulnerable, o_Blink});
    end
  endtask

  // Continues from grace offset 1 with collision still held past timer expiry.
  task automatic test_grace_hold();
    logic exp_inv, exp_blink;
    for (int o = 2; o <= 30; o++) begin
      if (o == 26) col = 1'b0;
      step();
      exp_inv = (o <= 26);
      exp_blink = (o <= 26) ? (((o / 5) % 2) == 0) : 1'b0;
      checks++;
      if (o_Invulnerable !== exp_inv || o_Blink !== exp_blink || o_Hit !== 1'b0) begin
        errors++;
        $display("FAIL grace_hold@%0d: got inv %b blink %b hit %b expected inv %b blink %b hit 0",
                 o, o_Invulnerable, o_Blink, o_Hit, exp_inv, exp_blink);
      end
    end
    checks++;
    if (o_Lives !== 3'd2) begin
      errors++;
      $display("FAIL grace_lives: got %0d expected 2", o_Lives);
    end
  endtask

  task automatic test_game_over();
    int lat;
    int n;
    int seen;
    logic [2:0] exp_l;
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (o_Lives !== 3'd3) begin
      errors++;
      $display("FAIL go_restart_lives: got %0d expected 3", o_Lives);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      hit_wait(lat);
      exp_l = 3'(2 - i);
      checks++;
      if (lat != 4 || o_Lives !== exp_l) begin
        errors++;
        $display("FAIL go_hit%0d: got lat %0d lives %0d expected lat 4 lives %0d", i, lat,
                 o_Lives, exp_l);
      end
      checks++;
      if (o_Respawn !== (i < 2) || o_Game_Over !== (i == 2)) begin
        errors++;
        $display("FAIL go_flags%0d: got resp %b go %b expected resp %b go %b", i, o_Respawn,
                 o_Game_Over, (i < 2), (i == 2));
      end
      col = 1'b0;
      if (i < 2) begin
        n = 0;
        while (o_Invulnerable === 1'b1 && n < 40) begin
          step();
          n++;
        end
        checks++;
        if (o_Invulnerable !== 1'b0) begin
          errors++;
          $display("FAIL go_grace_exit%0d: got inv %b expected 0", i, o_Invulnerable);
        end
      end
    end
    col = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (o_Hit === 1'b1) seen++;
    end
    col = 1'b0;
    checks++;
    if (seen != 0 || o_Lives !== 3'd0 || o_Game_Over !== 1'b1) begin
      errors++;
      $display("FAIL dead_hold: got hits %0d lives %0d go %b expected hits 0 lives 0 go 1", seen,
               o_Lives, o_Game_Over);
    end
  endtask

  task automatic test_restart();
    int lat;
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (o_Lives !== 3'd3 || {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over} !== 5'b0)
    begin
      errors++;
      $display("FAIL restart_dead: got lives %0d flags %b expected lives 3 flags 00000", o_Lives,
               {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over});
    end
    step();
    col = 1'b1;
    repeat (3) step();
    restart = 1'b1;
    col = 1'b0;
    step();
    restart = 1'b0;
    checks++;
    if (o_Lives !== 3'd3 || {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over} !== 5'b0)
    begin
      errors++;
      $display("FAIL restart_confirm: got lives %0d flags %b expected lives 3 flags 00000",
               o_Lives, {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over});
    end
    step();
    hit_wait(lat);
    col = 1'b0;
    checks++;
    if (lat != 4 || o_Lives !== 3'd2) begin
      errors++;
      $display("FAIL restart_rehit: got lat %0d lives %0d expected lat 4 lives 2", lat, o_Lives);
    end
    repeat (5) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (o_Lives !== 3'd3 || {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over} !== 5'b0)
    begin
      errors++;
      $display("FAIL restart_grace: got lives %0d flags %b expected lives 3 flags 00000", o_Lives,
               {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over});
    end
    step();
  endtask

  task automatic test_freeze();
    int lat;
    hit_wait(lat);
    col = 1'b0;
    repeat (3) step();
    gs = 2'b10;
    col = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 15) gs = 2'b11;
      step();
      checks++;
      if ({o_Lives, o_Invulnerable, o_Blink, o_Hit, o_Respawn} !== {3'd2, 4'b1100}) begin
        errors++;
        $display("FAIL freeze@%0d: got lives %0d inv %b blink %b hit %b resp %b expected 2 1 1 0 0",
                 i, o_Lives, o_Invulnerable, o_Blink, o_Hit, o_Respawn);
      end
    end
    gs = 2'b01;
    col = 1'b0;
    for (int u = 1; u <= 17; u++) begin
      step();
      if (u == 1 || u == 2) begin
        checks++;
        if (o_Blink !== (u == 1)) begin
          errors++;
          $display("FAIL freeze_blink_resume@%0d: got %b expected %b", u, o_Blink, (u == 1));
        end
      end
      if (u == 16 || u == 17) begin
        checks++;
        if (o_Invulnerable !== (u == 16)) begin
          errors++;
          $display("FAIL freeze_timer_resume@%0d: got inv %b expected %b", u, o_Invulnerable,
                   (u == 16));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int lat;
    hit_wait(lat);
    col = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_Lives !== 3'd3 || {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over} !== 5'b0)
    begin
      errors++;
      $display("FAIL async_reset: got lives %0d flags %b expected lives 3 flags 00000", o_Lives,
               {o_Hit, o_Respawn, o_Invulnerable, o_Blink, o_Game_Over});
    end
    #20;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_short_collision();
    test_hit_latency();
    test_grace_hold();
    test_game_over();
    test_restart();
    test_freeze();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_manager.md
Name: hit_manager

Overview:
- Sits between the raccoon/car overlap comparator and the lives/game-state/VGA logic on the Go Board (25 MHz).
- Converts the raw, level-sensitive collision flag into one confirmed hit per impact.
- Enforces a post-hit invulnerability window, owns the lives counter, and issues respawn and game-over indications.
- Also provides a blink strobe so the VGA stage can flash the raccoon while it is invulnerable.

Parameters:
- START_LIVES, 3: lives loaded at reset and restart; must fit LIVES_W.
- LIVES_W, 3: width of o_Lives.
- CONFIRM_CYCLES, 4: consecutive registered-collision cycles required to count a hit; range 1..255.
- GRACE_CYCLES, 25000000: invulnerability length after a non-fatal hit (1 s at 25 MHz).
- BLINK_CYCLES, 3125000: half-period of o_Blink during grace (4 Hz flash).

Ports:
- i_Clk  in  1  system clock, 25 MHz
- i_Reset_n  in  1  asynchronous active-low reset
- i_Game_State  in  2  00 idle, 01 running, 10 win, 11 clean
- i_Collision  in  1  raw combinational overlap flag, same clock domain
- i_Restart  in  1  synchronous restart pulse
- o_Lives  out  LIVES_W  remaining lives
- o_Hit  out  1  one-cycle pulse per confirmed hit
- o_Respawn  out  1  one-cycle pulse; raccoon returns to its start position
- o_Invulnerable  out  1  high throughout GRACE
- o_Blink  out  1  flash strobe; 0 outside GRACE
- o_Game_Over  out  1  high in DEAD

Behaviour:
- Reset (i_Reset_n low, asynchronous): state IDLE; o_Lives=START_LIVES; all other outputs 0; all counters 0; collision_q=0.
- collision_q: i_Collision registered once. All decisions use collision_q only.
- Priority, highest first: reset, i_Restart, i_Game_State==00, then state logic.
- i_Restart or i_Game_State==00: next cycle state=IDLE, o_Lives=START_LIVES, counters cleared, outputs 0. This applies from every state, including mid-CONFIRM and mid-GRACE.
- i_Game_State 10 or 11: freeze. No state change, counters hold, no hit counted. Outputs hold, except o_Hit and o_Respawn, which are forced to 0.
- IDLE: go to ARMED when i_Game_State==01.
- ARMED: if collision_q=1, go to CONFIRM with confirm count=1.
- CONFIRM:
  - If collision_q=0, return to ARMED and clear the count.
  - Otherwise increment the count.
  - When the count reaches CONFIRM_CYCLES, register the hit: o_Hit=1 for one cycle and o_Lives decrements in the same cycle.
  - If the new lives value is 0: go to DEAD, o_Game_Over=1, and do not assert o_Respawn.
  - Otherwise: o_Respawn=1 in the same cycle as o_Hit, go to GRACE, grace timer = GRACE_CYCLES-1.
- Hit latency: with i_Collision rising before edge t and staying high, o_Hit is high in cycle t+CONFIRM_CYCLES.
- GRACE:
  - o_Invulnerable=1 and collision_q is ignored.
  - The grace timer decrements each cycle.
  - o_Blink starts at 1 on GRACE entry and toggles every BLINK_CYCLES cycles.
  - When the timer reaches 0: go to ARMED if collision_q=0. If collision_q=1, stay in GRACE (timer held at 0) until collision_q=0, then go to ARMED. A lingering overlap never produces a second hit.
  - On exit, o_Invulnerable=0 and o_Blink=0 in the same cycle.
- DEAD: o_Game_Over=1 and o_Lives=0, held until i_Restart or i_Game_State==00. Collisions are ignored.
- o_Lives saturates at 0 and never wraps. At most one hit per impact.
- Registered outputs only: no combinational path from any input to any output.

Test Plan (sim params: CONFIRM_CYCLES=4, GRACE_CYCLES=20, BLINK_CYCLES=5, START_LIVES=3):
1. Reset, then i_Game_State=01 -> o_Lives=3, all flags 0, state ARMED.
2. i_Collision high 3 cycles then low -> no o_Hit, o_Lives stays 3. i_Collision high 10 cycles -> exactly one o_Hit and one o_Respawn pulse, both 4 cycles after collision_q rises, o_Lives=2, o_Invulnerable=1.
3. During GRACE, hold i_Collision high through timer expiry -> o_Invulnerable stays 1 until i_Collision drops, then 0 the next cycle, and no extra hit. Check o_Blink toggles every 5 cycles starting at 1.
4. Three separated confirmed hits -> o_Lives goes 3,2,1,0. The third hit gives o_Hit with no o_Respawn and o_Game_Over=1. Further collisions leave o_Lives at 0.
5. Pulse i_Restart mid-CONFIRM and mid-GRACE -> next cycle o_Lives=3, all flags 0, state IDLE. With i_Game_State=10 and collision held, o_Lives and the timer stay frozen.
6. Assert i_Reset_n low asynchronously mid-GRACE -> outputs reach reset values immediately, without waiting for a clock edge.
